rng_word_packer: RTL

Downstream consumer of the RNG host's random word stream. It accepts narrow random samples on a valid strobe and runs a repetition-count health test on every sample. Passing samples are packed LSB-first into 64-bit words and buffered in a small first-word-fall-through FIFO. The FIFO feeds a valid/ready consumer such as a key-material or DMA stage.

---
 rtl/rng_word_packer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/rng_word_packer.sv
// rng_word_packer: health-checks narrow RNG samples and packs passing samples
// LSB-first into wide words. The words are buffered in a small FWFT FIFO.
// Ports:
//   clk, rst (async, active high)
//   in_valid / in_data     : sample strobe and sample, no backpressure
//   clear_fail             : pulse that clears the sticky health failure
//   out_valid / out_ready / out_data : FIFO head handshake
//   fifo_level, health_fail, drop_count : status outputs
module rng_word_packer #(
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int REP_LIMIT  = 4,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 clear_fail,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [LW-1:0]        fifo_level,
    output logic                 health_fail,
    output logic [7:0]           drop_count
);
    localparam int SLICES = OUT_WIDTH / IN_WIDTH;
    localparam int CW = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int RW = $clog2(REP_LIMIT + 1);

    typedef enum logic {FILL, FAIL} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]  word_q, word_d, word_nxt;
    logic [IN_WIDTH-1:0]   prev_q, prev_d;
    logic                  prev_vld_q, prev_vld_d;
    logic [RW-1:0]         rep_q, rep_d, rep_inc;
    logic                  same;
    logic                  push_req, push_ok, pop;

    logic [OUT_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;

    assign rep_inc = rep_q + RW'(1);
    // A clear_fail in FILL forgets the history, so this sample starts a new run
    assign same = prev_vld_q && !clear_fail && (in_data == prev_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        rep_d      = rep_q;
        push_req   = 1'b0;
        word_nxt   = word_q;
        word_nxt[int'(cnt_q)*IN_WIDTH +: IN_WIDTH] = in_data;
        unique case (state_q)
            FILL: begin
                if (clear_fail) begin
                    prev_vld_d = 1'b0;
                    rep_d      = '0;
                end
                if (in_valid) begin
                    if (same && rep_inc == RW'(REP_LIMIT)) begin
                        // Tripping sample is dropped with the partial word
                        state_d = FAIL;
                        cnt_d   = '0;
                    end else begin
                        prev_d     = in_data;
                        prev_vld_d = 1'b1;
                        rep_d      = same ? rep_inc : RW'(1);
                        word_d     = word_nxt;
                        if (cnt_q == CW'(SLICES - 1)) begin
                            cnt_d    = '0;
                            push_req = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
            FAIL: begin
                if (clear_fail) begin
                    state_d    = FILL;
                    cnt_d      = '0;
                    rep_d      = '0;
                    prev_vld_d = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            word_q     <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            rep_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            rep_q      <= rep_d;
        end
    end

    // Fullness comes from the level counter, so equal pointers are unambiguous
    assign out_valid = (fifo_level != '0);
    assign pop       = out_valid && out_ready;
    assign push_ok   = push_req && ((fifo_level < LW'(FIFO_DEPTH)) || pop);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign health_fail = (state_q == FAIL);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= word_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            drop_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop) begin
                fifo_level <= fifo_level + LW'(1);
            end else if (pop && !push_ok) begin
                fifo_level <= fifo_level - LW'(1);
            end
            if (push_req && !push_ok && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end
endmodule
